// File: rtl/vga_pkg.sv
// Shared types, constants and clock-configuration table for the VGA clock
// reconfiguration controller and its AXI4-Lite write engine.
package vga_pkg;

  localparam int unsigned     VGA_RES_NUM      = 2;
  localparam logic [1:0]      AXI_RESP_OKAY    = 2'b00;
  localparam logic [31:0]     VGA_CLK_CMD_LOAD = 32'h0000_0003;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_PRE_LOCK    = 4'd1,
    ST_WR_CFG0     = 4'd2,
    ST_WR_CLKOUT   = 4'd3,
    ST_WR_CMD      = 4'd4,
    ST_WAIT_UNLOCK = 4'd5,
    ST_WAIT_LOCK   = 4'd6,
    ST_DONE        = 4'd7,
    ST_ERR         = 4'd8
  } ctrl_state_e;

  typedef struct packed {
    logic [7:0]      divclk;
    logic [7:0]      mult_int;
    logic [9:0]      mult_frac;
    logic [6:0][7:0] clkout_int;
    logic [6:0][9:0] clkout_frac;
  } vga_clk_cfg_s;

  // 800x600 @ 40 MHz and 1280x1024 @ 108 MHz from a 100 MHz reference (VCO 1000 / 1080 MHz)
  localparam vga_clk_cfg_s VGA_CLK_CFG [VGA_RES_NUM] = '{
    '{divclk: 8'd1, mult_int: 8'd10, mult_frac: 10'd0,
      clkout_int: {8'd25, 8'd25, 8'd25, 8'd25, 8'd100, 8'd50, 8'd25}, clkout_frac: 70'd0},
    '{divclk: 8'd1, mult_int: 8'd10, mult_frac: 10'd800,
      clkout_int: {8'd10, 8'd10, 8'd10, 8'd10, 8'd40, 8'd20, 8'd10}, clkout_frac: 70'd0}
  };

  function automatic logic [31:0] cfg0_word(input vga_clk_cfg_s cfg);
    return {6'd0, cfg.mult_frac, cfg.mult_int, cfg.divclk};
  endfunction

  function automatic logic [31:0] clkout_word(input vga_clk_cfg_s cfg, input logic [2:0] k);
    return {14'd0, cfg.clkout_frac[k], cfg.clkout_int[k]};
  endfunction

endpackage

// File: rtl/axil_single_write.sv
// One AXI4-Lite write per start pulse; AW and W handshake independently,
// done_o pulses for one cycle after the B handshake with the captured response.
module axil_single_write #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_100m_i,
  input  logic              arstn_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              done_o,
  output logic [1:0]        resp_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o
);

  assign m_wstrb_o = 4'hF;

  // Channel valids, held address/data and response capture
  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_awaddr_o  <= '0;
      m_wdata_o   <= 32'd0;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_bready_o  <= 1'b0;
      done_o      <= 1'b0;
      resp_o      <= 2'b00;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        m_awaddr_o  <= addr_i;
        m_wdata_o   <= data_i;
        m_awvalid_o <= 1'b1;
        m_wvalid_o  <= 1'b1;
        m_bready_o  <= 1'b1;
      end else begin
        if (m_awvalid_o && m_awready_i) m_awvalid_o <= 1'b0;
        if (m_wvalid_o && m_wready_i)   m_wvalid_o  <= 1'b0;
        if (m_bready_o && m_bvalid_i) begin
          m_bready_o <= 1'b0;
          done_o     <= 1'b1;
          resp_o     <= m_bresp_i;
        end
      end
    end
  end

endmodule

// File: rtl/vga_clk_reconf_ctrl.sv
// Sequences the clocking-wizard DRP register writes for a requested VGA mode,
// then waits for the MMCM to drop and regain lock before reporting done.
module vga_clk_reconf_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned       NUM_RES       = 2,
  parameter int unsigned       NUM_CLKOUT    = 1,
  parameter int unsigned       ADDR_W        = 11,
  parameter logic [ADDR_W-1:0] CFG0_ADDR     = 11'h200,
  parameter logic [ADDR_W-1:0] CLKOUT0_ADDR  = 11'h208,
  parameter logic [ADDR_W-1:0] CLKOUT_STRIDE = 11'h00C,
  parameter logic [ADDR_W-1:0] CMD_ADDR      = 11'h25C,
  parameter int unsigned       LOCK_TIMEOUT  = 100000,
  localparam int unsigned      RES_W         = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
  input  logic              clk_100m_i,
  input  logic              arstn_i,
  input  logic [RES_W-1:0]  resolution_i,
  input  logic              req_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              locked_i,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  ctrl_state_e       state_r, state_next_s;
  vga_clk_cfg_s      cfg_r;
  logic [2:0]        k_r;
  logic              wr_pend_r, wr_start_s, wr_done_s, wr_fail_s, tmo_s;
  logic [1:0]        wr_resp_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [31:0]       wr_data_s;
  logic [CNT_W-1:0]  tmo_cnt_r;
  logic              locked_meta_r, locked_sync_r;
  logic              busy_r, done_r, err_r;

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign err_o  = err_r;

  // Two-flop synchroniser for the asynchronous MMCM lock indication
  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      locked_meta_r <= locked_i;
      locked_sync_r <= locked_meta_r;
    end
  end

  // Next state and write-engine command; each write state issues once, then waits for B
  always_comb begin
    state_next_s = state_r;
    wr_start_s   = 1'b0;
    wr_addr_s    = '0;
    wr_data_s    = 32'd0;
    tmo_s        = (tmo_cnt_r == CNT_W'(LOCK_TIMEOUT - 1));
    wr_fail_s    = wr_done_s && (wr_resp_s != AXI_RESP_OKAY);
    case (state_r)
      ST_IDLE: begin
        if (req_i) state_next_s = ST_PRE_LOCK;
        else       state_next_s = ST_IDLE;
      end
      ST_PRE_LOCK: begin
        if (locked_sync_r) state_next_s = ST_WR_CFG0;
        else if (tmo_s)    state_next_s = ST_ERR;
        else               state_next_s = ST_PRE_LOCK;
      end
      ST_WR_CFG0: begin
        wr_addr_s  = CFG0_ADDR;
        wr_data_s  = cfg0_word(cfg_r);
        wr_start_s = !wr_pend_r;
        if (wr_fail_s)      state_next_s = ST_ERR;
        else if (wr_done_s) state_next_s = ST_WR_CLKOUT;
        else                state_next_s = ST_WR_CFG0;
      end
      ST_WR_CLKOUT: begin
        wr_addr_s  = CLKOUT0_ADDR + ADDR_W'(k_r) * CLKOUT_STRIDE;
        wr_data_s  = clkout_word(cfg_r, k_r);
        wr_start_s = !wr_pend_r;
        if (wr_fail_s)                                   state_next_s = ST_ERR;
        else if (wr_done_s && (k_r == 3'(NUM_CLKOUT - 1))) state_next_s = ST_WR_CMD;
        else                                             state_next_s = ST_WR_CLKOUT;
      end
      ST_WR_CMD: begin
        wr_addr_s  = CMD_ADDR;
        wr_data_s  = VGA_CLK_CMD_LOAD;
        wr_start_s = !wr_pend_r;
        if (wr_fail_s)      state_next_s = ST_ERR;
        else if (wr_done_s) state_next_s = ST_WAIT_UNLOCK;
        else                state_next_s = ST_WR_CMD;
      end
      ST_WAIT_UNLOCK: begin
        // A reconfig to the same frequency may never drop lock; that is not a failure
        if (!locked_sync_r || tmo_s) state_next_s = ST_WAIT_LOCK;
        else                         state_next_s = ST_WAIT_UNLOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_sync_r) state_next_s = ST_DONE;
        else if (tmo_s)    state_next_s = ST_ERR;
        else               state_next_s = ST_WAIT_LOCK;
      end
      ST_DONE: state_next_s = ST_IDLE;
      ST_ERR:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, status outputs, latched config, clkout index and lock-wait timer
  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cfg_r     <= '0;
      k_r       <= 3'd0;
      wr_pend_r <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
      if ((state_r == ST_IDLE) && req_i) begin
        err_r <= 1'b0;
        cfg_r <= VGA_CLK_CFG[resolution_i];
      end else if (state_next_s == ST_ERR) begin
        err_r <= 1'b1;
      end
      if (wr_start_s)     wr_pend_r <= 1'b1;
      else if (wr_done_s) wr_pend_r <= 1'b0;
      if (state_r != ST_WR_CLKOUT) k_r <= 3'd0;
      else if (wr_done_s)          k_r <= k_r + 3'd1;
      if (state_next_s != state_r) tmo_cnt_r <= '0;
      else if ((state_r == ST_PRE_LOCK) || (state_r == ST_WAIT_UNLOCK) ||
               (state_r == ST_WAIT_LOCK)) tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end

  axil_single_write #(.ADDR_W(ADDR_W)) u_wr (
    .clk_100m_i  (clk_100m_i),
    .arstn_i     (arstn_i),
    .start_i     (wr_start_s),
    .addr_i      (wr_addr_s),
    .data_i      (wr_data_s),
    .done_o      (wr_done_s),
    .resp_o      (wr_resp_s),
    .m_awaddr_o  (m_awaddr_o),
    .m_awvalid_o (m_awvalid_o),
    .m_awready_i (m_awready_i),
    .m_wdata_o   (m_wdata_o),
    .m_wstrb_o   (m_wstrb_o),
    .m_wvalid_o  (m_wvalid_o),
    .m_wready_i  (m_wready_i),
    .m_bresp_i   (m_bresp_i),
    .m_bvalid_i  (m_bvalid_i),
    .m_bready_o  (m_bready_o)
  );

endmodule
